rgmii_clock_downsample: RTL and testbench

// - Programmable clock divider for RGMII speed support. Produces a square wave from a fast reference clock.
// - Output period is 2*(val_i+1) input cycles; output toggles every val_i+1 input cycles.
// - Divide settings: val_i=0 gives /2 (125 MHz from 250 MHz, 1000M), val_i=4 gives /10 (25 MHz, 100M),
//   val_i=49 gives /100 (2.5 MHz, 10M). To get divide-by-X, set val_i = X/2 - 1.
// - Sits between the internal 250 MHz source and the RGMII TX/RX clock generators.

---
 rtl/rgmii_clock_downsample_if.sv | 17 +
 rtl/rgmii_clock_downsample.sv | 66 ++++++
 tb/tb_rgmii_clock_downsample.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rgmii_clock_downsample_if.sv
// Divider control/output bundle for rgmii_clock_downsample.
// Optional tick_o strobe is present only when RGMII_CLK_DS_TICK_EN is defined.
interface rgmii_clock_downsample_if #(
    parameter int unsigned width_p = 7
);
    logic [width_p-1:0] val_i;
    logic               clk_r_o;
`ifdef RGMII_CLK_DS_TICK_EN
    logic               tick_o;

    modport master (output val_i, input clk_r_o, input tick_o);
    modport slave  (input val_i, output clk_r_o, output tick_o);
`else
    modport master (output val_i, input clk_r_o);
    modport slave  (input val_i, output clk_r_o);
`endif
endinterface

// File: rtl/rgmii_clock_downsample.sv
// Programmable 50% duty clock divider for RGMII speed selection.
// Output half-period is val_i+1 reference cycles; clk_r_o is driven straight
// from a flop so it cannot glitch and has no combinational input path.
// Optional feature: define RGMII_CLK_DS_TICK_EN to add the one-cycle tick_o
// strobe coincident with every clk_r_o transition.
module rgmii_clock_downsample #(
    parameter int unsigned width_p = 7
) (
    input  logic                     rgmii_txd_reference_clk,
    input  logic                     rgmii_rx_rst_i,
    rgmii_clock_downsample_if.slave  bus
);

    logic [1:0]         rst_sync_r;
    logic               rst_n_s;
    logic [width_p-1:0] ctr_r;
    logic               clk_r;
    logic               toggle_w;

    // Reset synchroniser: asserts asynchronously, releases after two edges.
    always_ff @(posedge rgmii_txd_reference_clk or negedge rgmii_rx_rst_i) begin
        if (!rgmii_rx_rst_i) begin
            rst_sync_r <= '0;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Half-period reached; >= lets a shrinking val_i toggle on the next edge.
    always_comb begin
        toggle_w = (ctr_r >= bus.val_i);
    end

    // Half-period counter and divided clock register.
    always_ff @(posedge rgmii_txd_reference_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            ctr_r <= '0;
            clk_r <= 1'b0;
        end else if (toggle_w) begin
            ctr_r <= '0;
            clk_r <= ~clk_r;
        end else begin
            ctr_r <= ctr_r + 1'b1;
        end
    end

    assign bus.clk_r_o = clk_r;

`ifdef RGMII_CLK_DS_TICK_EN
    logic tick_r;

    // Strobe registered alongside clk_r so it coincides with each transition.
    always_ff @(posedge rgmii_txd_reference_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= toggle_w;
        end
    end

    assign bus.tick_o = tick_r;
`endif

endmodule

// File: tb/tb_rgmii_clock_downsample.sv
// Self-checking bench for rgmii_clock_downsample: directed divide ratios,
// mid-count val_i change, async reset, plus randomized val_i/reset traffic
// against a cycle-level reference model and observed run-length checks.
module tb_rgmii_clock_downsample;

    localparam int unsigned W = 7;

    logic clk;
    logic rst_n;

    rgmii_clock_downsample_if #(.width_p(W)) bus ();

    rgmii_clock_downsample #(.width_p(W)) dut (
        .rgmii_txd_reference_clk (clk),
        .rgmii_rx_rst_i          (rst_n),
        .bus                     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_sync;      // edges seen since reset release, saturates at 2
    int m_elapsed;   // cycles since the last toggle
    bit m_clk;
    bit m_tick;

    // Observation of the DUT output waveform
    bit last_obs;
    int run_len;
    int prev_run;
    int rises;
    int edges;
    int first_rise_edge;
    bit tog;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync    = 0;
        m_elapsed = 0;
        m_clk     = 1'b0;
        m_tick    = 1'b0;
    endtask

    task automatic obs_reset();
        last_obs        = 1'b0;
        run_len         = 0;
        prev_run        = 0;
        rises           = 0;
        edges           = 0;
        first_rise_edge = -1;
    endtask

    // One reference-clock cycle: update model at posedge, compare at negedge.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (m_sync < 2) begin
                m_sync++;
            end else if (m_elapsed >= int'(bus.val_i)) begin
                m_elapsed = 0;
                m_clk     = ~m_clk;
                m_tick    = 1'b1;
            end else begin
                m_elapsed++;
                m_tick = 1'b0;
            end
        end
        edges++;
        @(negedge clk);
        check_val("clk_r_o", int'(bus.clk_r_o), int'(m_clk));
`ifdef RGMII_CLK_DS_TICK_EN
        check_val("tick_o", int'(bus.tick_o), int'(m_tick));
`endif
        tog = 1'b0;
        if (bus.clk_r_o == last_obs) begin
            run_len++;
        end else begin
            tog      = 1'b1;
            prev_run = run_len;
            run_len  = 1;
            last_obs = bus.clk_r_o;
            if (bus.clk_r_o) begin
                rises++;
                if (first_rise_edge < 0) first_rise_edge = edges;
            end
        end
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic assert_reset(input int hold);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_clk_immediate", int'(bus.clk_r_o), 0);
`ifdef RGMII_CLK_DS_TICK_EN
        check_val("rst_tick_immediate", int'(bus.tick_o), 0);
`endif
        @(negedge clk);
        for (int i = 0; i < hold; i++) step();
        rst_n = 1'b1;
        obs_reset();
    endtask

    task automatic wait_toggle(input int bound);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tog && n < bound);
        if (!tog) check_val("toggle_timeout", 0, 1);
    endtask

    // Reset, check first-rise latency, then check a number of half-periods.
    task automatic run_pattern(input int v, input int nrun, input string tag);
        bus.val_i = W'(v);
        assert_reset(2);
        while (rises == 0 && edges < 2 * v + 20) step();
        check_val({tag, "_first_rise"}, first_rise_edge, v + 3);
        for (int i = 0; i < nrun; i++) begin
            wait_toggle(2 * v + 10);
            check_val({tag, "_half_period"}, prev_run, v + 1);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        bus.val_i = '0;
        model_reset();
        obs_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check_val("reset_clk", int'(bus.clk_r_o), 0);
`ifdef RGMII_CLK_DS_TICK_EN
        check_val("reset_tick", int'(bus.tick_o), 0);
`endif
        @(negedge clk);
        step();
        rst_n = 1'b1;
        obs_reset();

        // Divide by 2: 1000 edges after sync give 500 rising edges.
        for (int i = 0; i < 2; i++) step();
        rises = 0;
        for (int i = 0; i < 1000; i++) step();
        check_val("div2_rises", rises, 500);

        run_pattern(4, 6, "div10");
        run_pattern(49, 4, "div100");
        run_pattern((1 << W) - 1, 2, "div_max");

        // val_i 49 -> 4 while the counter sits at 20.
        run_pattern(49, 1, "chg");
        for (int i = 0; i < 20; i++) step();
        bus.val_i = W'(4);
        step();
        check_val("chg_next_edge_toggle", int'(tog), 1);
        check_val("chg_no_runt", prev_run, 21);
        for (int i = 0; i < 4; i++) begin
            wait_toggle(20);
            check_val("chg_new_half_period", prev_run, 5);
        end

        // Reset mid high half-period, count restarts from zero.
        run_pattern(49, 0, "midrst");
        for (int i = 0; i < 10; i++) step();
        check_val("midrst_was_high", int'(bus.clk_r_o), 1);
        assert_reset(3);
        while (rises == 0 && edges < 200) step();
        check_val("midrst_restart", first_rise_edge, 52);

        // Randomized val_i changes and reset pulses against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) bus.val_i = W'($urandom_range(0, (1 << W) - 1));
                else                           bus.val_i = W'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 399) == 0) assert_reset(int'($urandom_range(1, 3)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
